image_mode_ctrl: RTL and testbench

//   Frame-synchronous controller for the image_mode bus that drives the processing

---
 rtl/image_mode_ctrl_if.sv | 13 +
 rtl/image_mode_ctrl.sv | 84 ++++++++
 tb/tb_image_mode_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/image_mode_ctrl_if.sv
// Command channel into image_mode_ctrl: valid/ready handshake carrying a mode request
// or an auto-cycle request.
interface image_mode_ctrl_if;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [7:0] cmd_mode_i;
   logic       cmd_auto_i;

   modport master (output cmd_valid_i, output cmd_mode_i, output cmd_auto_i,
                   input  cmd_ready_o);
   modport slave  (input  cmd_valid_i, input  cmd_mode_i, input  cmd_auto_i,
                   output cmd_ready_o);
endinterface

// File: rtl/image_mode_ctrl.sv
// Frame-synchronous driver of the image_mode bus: mode changes land only on the vs
// falling edge so downstream blocks capturing on vs rise never see a mid-frame change.
module image_mode_ctrl #(
   parameter int NUM_MODES   = 4,
   parameter int AUTO_FRAMES = 120,
   parameter int FCNT_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              vs_i,
   image_mode_ctrl_if.slave  cmd,
   output logic [7:0]        image_mode_o,
   output logic              pending_o,
   output logic              auto_o,
   output logic              err_o,
   output logic [FCNT_W-1:0] frame_cnt_o
);
   localparam int ACNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [8:0]        NUM_MODES_W = 9'(NUM_MODES);
   localparam logic [7:0]        LAST_MODE   = 8'(NUM_MODES - 1);
   localparam logic [ACNT_W-1:0] LAST_CNT    = ACNT_W'(AUTO_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, PEND, AUTO} state_t;

   state_t            state;
   logic              vs_d;
   logic [7:0]        pend_mode;
   logic [ACNT_W-1:0] auto_cnt;
   logic [7:0]        auto_tgt;
   logic              vs_rise, vs_fall, hs, mode_ok;

   assign vs_rise         = vs_i & ~vs_d;
   assign vs_fall         = ~vs_i & vs_d;
   assign cmd.cmd_ready_o = (state != PEND);
   assign hs              = cmd.cmd_valid_i & cmd.cmd_ready_o;
   assign mode_ok         = ({1'b0, cmd.cmd_mode_i} < NUM_MODES_W);
   assign pending_o       = (state == PEND);
   assign auto_o          = (state == AUTO);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         vs_d         <= vs_i;
         image_mode_o <= 8'd0;
         pend_mode    <= 8'd0;
         auto_cnt     <= '0;
         auto_tgt     <= 8'd0;
         err_o        <= 1'b0;
         frame_cnt_o  <= '0;
      end else begin
         vs_d  <= vs_i;
         err_o <= 1'b0;
         if (vs_rise) frame_cnt_o <= frame_cnt_o + FCNT_W'(1);
         // A command wins over a coincident vs_fall; it is applied on the next one.
         if (hs) begin
            if (cmd.cmd_auto_i) begin
               state    <= AUTO;
               auto_cnt <= '0;
               auto_tgt <= 8'd0;
            end else if (mode_ok) begin
               state     <= PEND;
               pend_mode <= cmd.cmd_mode_i;
            end else begin
               err_o <= 1'b1;
            end
         end else if (vs_fall) begin
            case (state)
               PEND: begin
                  image_mode_o <= pend_mode;
                  state        <= IDLE;
               end
               AUTO: begin
                  if (auto_cnt == '0) begin
                     image_mode_o <= auto_tgt;
                     auto_tgt     <= (auto_tgt == LAST_MODE) ? 8'd0 : auto_tgt + 8'd1;
                  end
                  auto_cnt <= (auto_cnt == LAST_CNT) ? '0 : auto_cnt + ACNT_W'(1);
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_image_mode_ctrl.sv
// Directed bench for image_mode_ctrl: a vector table for the manual/reset paths plus
// hand sequences for auto-cycle, command priority and frame counter wrap.
module tb_image_mode_ctrl;
   logic       clock = 1'b0;
   logic       reset;
   logic       vs_i;
   logic [7:0] image_mode_o;
   logic       pending_o, auto_o, err_o;
   logic [3:0] frame_cnt_o;
   int         n_vec = 0;
   int         n_err = 0;

   image_mode_ctrl_if cif();

   image_mode_ctrl #(.NUM_MODES(4), .AUTO_FRAMES(3), .FCNT_W(4)) dut (
      .clock(clock), .reset(reset), .vs_i(vs_i), .cmd(cif.slave),
      .image_mode_o(image_mode_o), .pending_o(pending_o), .auto_o(auto_o),
      .err_o(err_o), .frame_cnt_o(frame_cnt_o));

   always #5 clock = ~clock;

   typedef struct {
      logic       rst, vs, vld;
      logic [7:0] mode;
      logic       au;
      int         e_mode, e_pend, e_auto, e_rdy, e_err, e_fcnt;
   } vec_t;

   vec_t tv[21];

   function automatic vec_t mk(input logic rst, vs, vld, input logic [7:0] mode,
                               input logic au, input int em, ep, ea, er, ee, ef);
      vec_t v;
      v.rst = rst; v.vs = vs; v.vld = vld; v.mode = mode; v.au = au;
      v.e_mode = em; v.e_pend = ep; v.e_auto = ea; v.e_rdy = er; v.e_err = ee; v.e_fcnt = ef;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, vs, vld, input logic [7:0] mode, input logic au);
      @(negedge clock);
      reset = rst; vs_i = vs;
      cif.cmd_valid_i = vld; cif.cmd_mode_i = mode; cif.cmd_auto_i = au;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; vs_i = 1'b1;
      cif.cmd_valid_i = 1'b0; cif.cmd_mode_i = 8'd0; cif.cmd_auto_i = 1'b0;

      //            rst vs vld mode au   mode pend auto rdy err fcnt
      tv[0]  = mk(1, 1, 0, 8'd0, 0,  0, 0, 0, 1, 0, 0);
      tv[1]  = mk(1, 1, 0, 8'd0, 0,  0, 0, 0, 1, 0, 0);
      tv[2]  = mk(0, 1, 0, 8'd0, 0,  0, 0, 0, 1, 0, 0);
      tv[3]  = mk(0, 0, 0, 8'd0, 0,  0, 0, 0, 1, 0, 0);
      tv[4]  = mk(0, 1, 0, 8'd0, 0,  0, 0, 0, 1, 0, 1);
      tv[5]  = mk(0, 1, 1, 8'd2, 0,  0, 1, 0, 0, 0, 1);
      tv[6]  = mk(0, 1, 1, 8'd3, 0,  0, 1, 0, 0, 0, 1);
      tv[7]  = mk(0, 0, 0, 8'd0, 0,  2, 0, 0, 1, 0, 1);
      tv[8]  = mk(0, 0, 0, 8'd0, 0,  2, 0, 0, 1, 0, 1);
      tv[9]  = mk(0, 0, 1, 8'd7, 0,  2, 0, 0, 1, 1, 1);
      tv[10] = mk(0, 0, 0, 8'd0, 0,  2, 0, 0, 1, 0, 1);
      tv[11] = mk(0, 1, 0, 8'd0, 0,  2, 0, 0, 1, 0, 2);
      tv[12] = mk(0, 0, 1, 8'd1, 0,  2, 1, 0, 0, 0, 2);
      tv[13] = mk(0, 1, 0, 8'd0, 0,  2, 1, 0, 0, 0, 3);
      tv[14] = mk(0, 0, 0, 8'd0, 0,  1, 0, 0, 1, 0, 3);
      tv[15] = mk(0, 1, 0, 8'd0, 0,  1, 0, 0, 1, 0, 4);
      tv[16] = mk(0, 1, 1, 8'd3, 0,  1, 1, 0, 0, 0, 4);
      tv[17] = mk(1, 1, 0, 8'd0, 0,  0, 0, 0, 1, 0, 0);
      tv[18] = mk(0, 0, 0, 8'd0, 0,  0, 0, 0, 1, 0, 0);
      tv[19] = mk(0, 1, 0, 8'd0, 0,  0, 0, 0, 1, 0, 1);
      tv[20] = mk(0, 0, 0, 8'd0, 0,  0, 0, 0, 1, 0, 1);

      foreach (tv[i]) begin
         step(tv[i].rst, tv[i].vs, tv[i].vld, tv[i].mode, tv[i].au);
         chk($sformatf("v%0d.mode", i), int'(image_mode_o), tv[i].e_mode);
         chk($sformatf("v%0d.pend", i), int'(pending_o), tv[i].e_pend);
         chk($sformatf("v%0d.auto", i), int'(auto_o), tv[i].e_auto);
         chk($sformatf("v%0d.rdy", i), int'(cif.cmd_ready_o), tv[i].e_rdy);
         chk($sformatf("v%0d.err", i), int'(err_o), tv[i].e_err);
         chk($sformatf("v%0d.fcnt", i), int'(frame_cnt_o), tv[i].e_fcnt);
      end

      // auto-cycle entry; mode field must be ignored, no error
      step(0, 0, 1, 8'd7, 1);
      chk("auto_enter.auto", int'(auto_o), 1);
      chk("auto_enter.mode", int'(image_mode_o), 0);
      chk("auto_enter.err", int'(err_o), 0);
      chk("auto_enter.rdy", int'(cif.cmd_ready_o), 1);

      // 15 frames at 3 frames/mode; frame counter passes 15 -> 0
      for (int k = 0; k < 15; k++) begin
         step(0, 1, 0, 8'd0, 0);
         chk($sformatf("auto_f%0d.fcnt", k), int'(frame_cnt_o), (2 + k) % 16);
         step(0, 0, 0, 8'd0, 0);
         chk($sformatf("auto_f%0d.mode", k), int'(image_mode_o), (k / 3) % 4);
      end

      // invalid command while auto-cycling
      step(0, 0, 1, 8'd9, 0);
      chk("auto_bad.err", int'(err_o), 1);
      chk("auto_bad.auto", int'(auto_o), 1);
      step(0, 0, 0, 8'd0, 0);
      chk("auto_bad.err_clr", int'(err_o), 0);
      chk("auto_bad.auto_hold", int'(auto_o), 1);

      // manual command on the vs_fall where auto would have stepped to mode 1
      step(0, 1, 0, 8'd0, 0);
      step(0, 0, 1, 8'd3, 0);
      chk("auto_hs_fall.mode", int'(image_mode_o), 0);
      chk("auto_hs_fall.pend", int'(pending_o), 1);
      chk("auto_hs_fall.auto", int'(auto_o), 0);
      chk("auto_hs_fall.rdy", int'(cif.cmd_ready_o), 0);
      step(0, 1, 0, 8'd0, 0);
      step(0, 0, 0, 8'd0, 0);
      chk("auto_hs_apply.mode", int'(image_mode_o), 3);
      chk("auto_hs_apply.pend", int'(pending_o), 0);
      chk("auto_hs_apply.rdy", int'(cif.cmd_ready_o), 1);
      chk("auto_hs_apply.fcnt", int'(frame_cnt_o), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
